// File: rtl/decoder3to8_scan.sv
// 3-to-8 one-hot decoder with 7-segment output, hold register and optional auto-scan.
// Auto-scan (SCAN state and prescaler) is built only when the DEC_SCAN_EN macro is defined.
module decoder3to8_scan #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code,
    input  logic       load,
    input  logic       scan,
    output logic [7:0] led,
    output logic [6:0] hex,
    output logic       busy
);

`ifdef DEC_SCAN_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1
    } state_t;
`endif

    // Active-low segment pattern for one digit; anything off-table blanks the display.
    function automatic logic [6:0] digit(input logic [2:0] d);
        logic [6:0] seg;
        case (d)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            3'd7:    seg = 7'b1111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] idx_r;
    logic [2:0] idx_nxt_s;
    logic [7:0] led_nxt_s;
    logic [6:0] hex_nxt_s;
    logic       busy_nxt_s;

`ifdef DEC_SCAN_EN
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
`else
    logic scan_unused_s;
    assign scan_unused_s = scan;
`endif

    // State, index and prescaler register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
`ifdef DEC_SCAN_EN
            presc_r <= '0;
`endif
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
`ifdef DEC_SCAN_EN
            presc_r <= presc_nxt_s;
`endif
        end
    end

    // Next-state logic: load always wins over scan
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
`ifdef DEC_SCAN_EN
        presc_nxt_s = presc_r;
`endif
        if (load) begin
`ifdef DEC_SCAN_EN
            presc_nxt_s = '0;
`endif
            if (code[0]) begin
                state_nxt_s = ST_HOLD;
                idx_nxt_s   = code[3:1];
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_HOLD: begin
`ifdef DEC_SCAN_EN
                    if (scan) begin
                        state_nxt_s = ST_SCAN;
                        presc_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
`else
                    state_nxt_s = ST_HOLD;
`endif
                end
`ifdef DEC_SCAN_EN
                ST_SCAN: begin
                    if (scan) begin
                        state_nxt_s = ST_SCAN;
                        if (presc_r == PRESC_LAST) begin
                            idx_nxt_s   = idx_r + 3'd1;
                            presc_nxt_s = '0;
                        end else begin
                            presc_nxt_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        // Leaving the scan freezes the current index; partial tick is dropped
                        state_nxt_s = ST_HOLD;
                        presc_nxt_s = '0;
                    end
                end
`endif
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs land on the accepting edge
    always_comb begin
        led_nxt_s  = 8'h00;
        hex_nxt_s  = 7'b1111111;
        busy_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                led_nxt_s  = 8'h00;
                hex_nxt_s  = 7'b1111111;
                busy_nxt_s = 1'b0;
            end
            ST_HOLD: begin
                led_nxt_s  = 8'h01 << idx_nxt_s;
                hex_nxt_s  = digit(idx_nxt_s);
                busy_nxt_s = 1'b0;
            end
`ifdef DEC_SCAN_EN
            ST_SCAN: begin
                led_nxt_s  = 8'h01 << idx_nxt_s;
                hex_nxt_s  = digit(idx_nxt_s);
                busy_nxt_s = 1'b1;
            end
`endif
            default: begin
                led_nxt_s  = 8'h00;
                hex_nxt_s  = 7'b1111111;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led  <= 8'h00;
            hex  <= 7'b1111111;
            busy <= 1'b0;
        end else begin
            led  <= led_nxt_s;
            hex  <= hex_nxt_s;
            busy <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_decoder3to8_scan.sv
// Randomized self-checking bench for decoder3to8_scan; runs TICK_DIV=4 and TICK_DIV=1 side by side.
module tb_decoder3to8_scan;

    localparam int TD0 = 4;
    localparam int TD1 = 1;
`ifdef DEC_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       scan;
    logic [3:0] code;
    logic [7:0] led0, led1;
    logic [6:0] hex0, hex1;
    logic       busy0, busy1;

    int tests = 0;
    int fails = 0;

    // Model: mode 0=idle 1=hold 2=scan; scanned index = start + elapsed/div
    int m_mode[2];
    int m_idx[2];
    int m_start[2];
    int m_cnt[2];
    int divs[2] = '{TD0, TD1};
    logic [6:0] seg_tbl[8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    decoder3to8_scan #(.TICK_DIV(TD0)) dut0 (
        .clk(clk), .rst(rst), .code(code), .load(load), .scan(scan),
        .led(led0), .hex(hex0), .busy(busy0)
    );

    decoder3to8_scan #(.TICK_DIV(TD1)) dut1 (
        .clk(clk), .rst(rst), .code(code), .load(load), .scan(scan),
        .led(led1), .hex(hex1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]  = 0;
            m_idx[k]   = 0;
            m_start[k] = 0;
            m_cnt[k]   = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (load) begin
                if (code[0]) begin
                    m_mode[k] = 1;
                    m_idx[k]  = int'(code[3:1]);
                end else begin
                    m_mode[k] = 0;
                end
            end else if (SCAN_EN && m_mode[k] == 1 && scan) begin
                m_mode[k]  = 2;
                m_start[k] = m_idx[k];
                m_cnt[k]   = 0;
            end else if (m_mode[k] == 2) begin
                if (scan) begin
                    m_cnt[k]++;
                    m_idx[k] = (m_start[k] + m_cnt[k] / divs[k]) % 8;
                end else begin
                    m_mode[k] = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic [7:0] e_led;
            logic [6:0] e_hex;
            e_led = (m_mode[k] == 0) ? 8'h00 : 8'(1 << m_idx[k]);
            e_hex = (m_mode[k] == 0) ? 7'b1111111 : seg_tbl[m_idx[k]];
            chk($sformatf("%s_led%0d", tag, k), (k == 0) ? led0 : led1, e_led);
            chk($sformatf("%s_hex%0d", tag, k), (k == 0) ? hex0 : hex1, e_hex);
            chk($sformatf("%s_busy%0d", tag, k), (k == 0) ? busy0 : busy1, (m_mode[k] == 2) ? 1 : 0);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between clock edges
    task automatic rst_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        scan = 1'b0;
        code = 4'b0000;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset_noclk");
        #1 rst = 1'b0;
        #1 check_all("reset_rel");

        code = 4'b1011; load = 1'b1;
        cycle("ld5");
        chk("ld5_led", led0, 8'h20);
        chk("ld5_hex", hex0, 7'b0010010);
        code = 4'b0110;
        cycle("ldinv");
        chk("ldinv_led", led0, 8'h00);
        chk("ldinv_hex", hex0, 7'b1111111);
        load = 1'b0;
        scan = 1'b1;
        cycle("idle_scan");
        chk("idle_scan_led", led0, 8'h00);

`ifdef DEC_SCAN_EN
        scan = 1'b0; code = 4'b1101; load = 1'b1;
        cycle("ld6");
        load = 1'b0; scan = 1'b1;
        cycle("scan_enter");
        chk("scan_enter_busy", busy0, 1);
        chk("scan_enter_led", led0, 8'h40);
        repeat (4) cycle("scan_a");
        chk("scan_step_led", led0, 8'h80);
        repeat (4) cycle("scan_b");
        chk("scan_wrap_led", led0, 8'h01);
        code = 4'b0101; load = 1'b1;
        cycle("ld_prio");
        chk("ld_prio_led", led0, 8'h04);
        chk("ld_prio_hex", hex0, 7'b0100100);
        chk("ld_prio_busy", busy0, 0);
        load = 1'b0;
        repeat (3) cycle("rescan");
        rst_pulse("rst_mid");
        repeat (5) cycle("post_rst");
        chk("post_rst_led", led0, 8'h00);
        chk("post_rst_busy", busy0, 0);
`else
        scan = 1'b0; code = 4'b0111; load = 1'b1;
        cycle("ld3");
        load = 1'b0; scan = 1'b1;
        repeat (20) cycle("noscan");
        chk("noscan_led", led0, 8'h08);
        chk("noscan_busy", busy0, 0);
        rst_pulse("rst_mid");
        cycle("post_rst");
        chk("post_rst_led", led0, 8'h00);
`endif

        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 5) == 0);
            code = 4'($urandom);
            scan = ($urandom_range(0, 7) != 0);
            cycle("rnd");
            if ($urandom_range(0, 49) == 0) begin
                rst_pulse("rnd_rst");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
